// File: rtl/rvv_vrf_wb_arbiter.sv
// Round-robin write-back arbiter for the vector register file write port.
// Define RVV_WB_SCOREBOARD_EN to build the pending-write scoreboard (busy/sb_err).
module rvv_vrf_wb_arbiter #(
    parameter int VLEN     = 512,
    parameter int NUM_REGS = 32,
    parameter int NUM_REQ  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // Handshake: a requester holds valid/addr/data stable until it sees ready;
    // a transfer happens on any rising edge where valid && ready are both high.
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*5-1:0]    req_addr,
    input  logic [NUM_REQ*VLEN-1:0] req_data,
    output logic [4:0]              rd_addr,
    output logic [VLEN-1:0]         rd_data,
    output logic                    rd_we,
    input  logic                    rsv_valid,
    input  logic [4:0]              rsv_addr,
    output logic [NUM_REGS-1:0]     busy,
    output logic                    sb_err
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] win;
    logic          found;
    logic          xfer;

    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PW'(s);
    endfunction

    // Scan from ptr, wrapping, and take the first valid requester.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[wrap_idx(ptr, k)]) begin
                found = 1'b1;
                win   = wrap_idx(ptr, k);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        xfer      = found && rst_n;
        if (xfer) req_ready[win] = 1'b1;
        ptr_next = ptr;
        if (xfer) ptr_next = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            rd_we   <= 1'b0;
            rd_addr <= '0;
            rd_data <= '0;
        end else begin
            ptr   <= ptr_next;
            rd_we <= xfer;
            if (xfer) begin
                rd_addr <= req_addr[win*5 +: 5];
                rd_data <= req_data[win*VLEN +: VLEN];
            end
        end
    end

`ifdef RVV_WB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_next;
    logic                err_q;
    logic                err_next;

    // A reservation landing on the edge that retires the same register is a
    // fresh reservation, not a double booking; the set wins over the clear.
    always_comb begin
        busy_next = busy_q;
        err_next  = 1'b0;
        if (rd_we) begin
            if (!busy_q[rd_addr]) err_next = 1'b1;
            busy_next[rd_addr] = 1'b0;
        end
        if (rsv_valid) begin
            if (busy_q[rsv_addr] && !(rd_we && (rd_addr == rsv_addr))) err_next = 1'b1;
            busy_next[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_next;
            err_q  <= err_next;
        end
    end

    assign busy   = busy_q;
    assign sb_err = err_q;
`else
    logic unused_rsv;
    assign unused_rsv = ^{rsv_valid, rsv_addr};
    assign busy       = '0;
    assign sb_err     = 1'b0;
`endif

endmodule

// File: tb/tb_rvv_vrf_wb_arbiter.sv
// Self-checking bench for rvv_vrf_wb_arbiter: directed vectors, a cycle-level
// reference model with an expected write queue, and literal spot checks.
module tb_rvv_vrf_wb_arbiter;

    localparam int VLEN     = 512;
    localparam int NUM_REGS = 32;
    localparam int NUM_REQ  = 3;
    localparam int W        = 5 + VLEN;
`ifdef RVV_WB_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*5-1:0]    req_addr = '0;
    logic [NUM_REQ*VLEN-1:0] req_data = '0;
    logic [4:0]              rd_addr;
    logic [VLEN-1:0]         rd_data;
    logic                    rd_we;
    logic                    rsv_valid = 1'b0;
    logic [4:0]              rsv_addr = '0;
    logic [NUM_REGS-1:0]     busy;
    logic                    sb_err;

    rvv_vrf_wb_arbiter #(.VLEN(VLEN), .NUM_REGS(NUM_REGS), .NUM_REQ(NUM_REQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_we(rd_we),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .busy(busy), .sb_err(sb_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference model: pointer, write-back register, busy set, error pulse
    int                  m_ptr = 0;
    logic                m_rd_we = 1'b0;
    logic [4:0]          m_rd_addr = '0;
    logic [VLEN-1:0]     m_rd_data = '0;
    logic [NUM_REGS-1:0] m_busy = '0;
    logic                m_err = 1'b0;
    logic [W-1:0]        exp_q[$];

    function automatic int model_winner(input int p, input logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++)
            if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr = 0; m_rd_we = 0; m_rd_addr = 0; m_rd_data = 0;
            m_busy = '0; m_err = 0;
            exp_q.delete();
        end else begin
            int g;
            logic [NUM_REGS-1:0] nb;
            logic ne;
            nb = m_busy;
            ne = 1'b0;
            if (SB) begin
                if (m_rd_we) begin
                    ne = ne | !m_busy[m_rd_addr];
                    nb[m_rd_addr] = 1'b0;
                end
                if (rsv_valid) begin
                    ne = ne | (m_busy[rsv_addr] && !(m_rd_we && m_rd_addr == rsv_addr));
                    nb[rsv_addr] = 1'b1;
                end
            end
            m_busy = nb;
            m_err  = ne;
            g = model_winner(m_ptr, req_valid);
            m_rd_we = (g >= 0);
            if (g >= 0) begin
                m_rd_addr = req_addr[g*5 +: 5];
                m_rd_data = req_data[g*VLEN +: VLEN];
                m_ptr = (g + 1) % NUM_REQ;
                exp_q.push_back({m_rd_addr, m_rd_data});
            end
        end
    end

    // compare process, every cycle at the falling edge
    int                 c_w;
    logic [NUM_REQ-1:0] c_ready;
    logic [W-1:0]       c_e;
    always @(negedge clk) begin
        c_w = model_winner(m_ptr, req_valid);
        c_ready = '0;
        if (rst_n && c_w >= 0) c_ready[c_w] = 1'b1;
        chk("m_req_ready", req_ready, c_ready);
        chk("m_rd_we", rd_we, m_rd_we);
        chk("m_rd_addr", rd_addr, m_rd_addr);
        chkw("m_rd_data", {5'd0, rd_data}, {5'd0, m_rd_data});
        chk("m_busy", busy, m_busy);
        chk("m_sb_err", sb_err, m_err);
        chk("m_ptr", 64'(dut.ptr), 64'(m_ptr));
        if (rd_we) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL wb_stream: got write %0h expected none", rd_addr);
            end else begin
                c_e = exp_q.pop_front();
                chkw("wb_stream", {rd_addr, rd_data}, c_e);
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [VLEN-1:0] d);
        req_valid[i] = v;
        req_addr[i*5 +: 5] = a;
        req_data[i*VLEN +: VLEN] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsv_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [VLEN-1:0] a5;
    int grants[6];
    int exp_g[6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        a5 = {(VLEN/8){8'hA5}};

        // reset state, with requests pending that must not be granted
        req_valid = '1;
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_rd_we", rd_we, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chkw("rst_rd_data", {5'd0, rd_data}, '0);
        chk("rst_busy", busy, 0);
        chk("rst_sb_err", sb_err, 0);
        do_reset();

        // single request
        set_req(0, 1'b1, 5'd3, a5);
        @(negedge clk);
        chk("single_ready", req_ready, 3'b001);
        tick();
        set_req(0, 1'b0, 5'd0, '0);
        chk("single_we", rd_we, 1);
        chk("single_addr", rd_addr, 3);
        chkw("single_data", {5'd0, rd_data}, {5'd0, a5});
        chk("single_ptr", 64'(dut.ptr), 1);
        tick();
        chk("single_we_drop", rd_we, 0);
        chk("single_addr_hold", rd_addr, 3);

        // fairness: all three held valid
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 5'(10 + i), {(VLEN/32){32'(i * 256)}});
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            grants[n] = -1;
            for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) grants[n] = i;
            tick();
            if (grants[n] >= 0)
                set_req(grants[n], 1'b1, 5'(10 + grants[n]), {(VLEN/32){32'(grants[n] * 256 + n + 1)}});
            chk("fair_we", rd_we, 1);
        end
        for (int n = 0; n < 6; n++) chk("fair_grant", 64'(grants[n]), 64'(exp_g[n]));
        req_valid = '0;
        tick();

        // wrap and skip
        do_reset();
        set_req(1, 1'b1, 5'd20, a5);
        tick();
        chk("wrap_ptr2", 64'(dut.ptr), 2);
        set_req(0, 1'b1, 5'd21, ~a5);
        set_req(1, 1'b1, 5'd22, a5);
        @(negedge clk);
        chk("wrap_ready0", req_ready, 3'b001);
        tick();
        set_req(0, 1'b0, 5'd0, '0);
        chk("wrap_ptr1", 64'(dut.ptr), 1);
        chk("wrap_addr0", rd_addr, 21);
        @(negedge clk);
        chk("wrap_ready1", req_ready, 3'b010);
        tick();
        set_req(1, 1'b0, 5'd0, '0);
        chk("wrap_ptr_after", 64'(dut.ptr), 2);
        chk("wrap_addr1", rd_addr, 22);
        tick();

        // scoreboard lifecycle on v5
        do_reset();
        rsv_valid = 1'b1; rsv_addr = 5'd5;
        tick();
        rsv_valid = 1'b0;
        chk("sb5_set", busy[5], SB);
        set_req(1, 1'b1, 5'd5, a5);
        tick();
        set_req(1, 1'b0, 5'd0, '0);
        chk("sb5_we", rd_we, 1);
        chk("sb5_addr", rd_addr, 5);
        tick();
        chk("sb5_clear", busy[5], 0);
        chk("sb5_noerr", sb_err, 0);

        // double reservation of v7
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        tick();
        tick();
        rsv_valid = 1'b0;
        chk("sb7_err", sb_err, SB);
        chk("sb7_busy", busy[7], SB);
        tick();
        chk("sb7_err_pulse", sb_err, 0);

        // reserve v9, commit v9 while re-reserving it
        rsv_valid = 1'b1; rsv_addr = 5'd9;
        tick();
        rsv_valid = 1'b0;
        set_req(0, 1'b1, 5'd9, a5);
        tick();
        set_req(0, 1'b0, 5'd0, '0);
        rsv_valid = 1'b1; rsv_addr = 5'd9;
        tick();
        rsv_valid = 1'b0;
        chk("sb9_busy", busy[9], SB);
        chk("sb9_noerr", sb_err, 0);

        // commit to unreserved v2
        set_req(2, 1'b1, 5'd2, a5);
        tick();
        set_req(2, 1'b0, 5'd0, '0);
        tick();
        chk("sb2_err", sb_err, SB);
        chk("sb2_busy", busy[2], 0);
        tick();

        // reset mid-transfer
        do_reset();
        rsv_valid = 1'b1; rsv_addr = 5'd4;
        set_req(0, 1'b1, 5'd1, a5);
        tick();
        rsv_valid = 1'b0;
        set_req(0, 1'b0, 5'd0, '0);
        set_req(2, 1'b1, 5'd6, ~a5);
        chk("mid_we_before", rd_we, 1);
        chk("mid_busy_before", busy[4], SB);
        @(negedge clk);
        chk("mid_ready2", req_ready, 3'b100);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_we", rd_we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ptr", 64'(dut.ptr), 0);
        chk("mid_rst_ready", req_ready, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_re_ready", req_ready, 3'b100);
        tick();
        set_req(2, 1'b0, 5'd0, '0);
        chk("mid_re_we", rd_we, 1);
        chk("mid_re_addr", rd_addr, 6);
        chkw("mid_re_data", {5'd0, rd_data}, {5'd0, ~a5});
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
